// File: rtl/feature_col_feeder.sv
// ---------------------------------------------------------------------------
// feature_col_feeder
//   Column transmitter for vertical_reg. For every requested K x K window it
//   reads K column vectors from the feature line buffer (1-cycle read
//   latency), registers each one onto the column bus picked by in_select and
//   pulses enable at the start of the load. When vertical_reg reports
//   shift_done, in_select flips so the next window lands on the other bus.
//   The window origin advances by col_stride columns per window.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           1-cycle run request (ignored while busy)
//   kn_size_mode    kernel size select (K=5 or K=3), latched at start
//   base_addr       column address of window 0, column 0
//   col_stride      address step between windows
//   num_windows     windows in this run
//   compute_ready   downstream can take the next window load
//   rd_en, rd_addr  line-buffer read strobe / address
//   rd_data         line-buffer data, valid the cycle after rd_en
//   enable          one-cycle pulse to vertical_reg at the start of a load
//   in_select       selects which column bus feeds vertical_reg
//   dia_0, dia_1    registered column buses
//   shift_done      vertical_reg finished shifting the window in
//   win_loaded      one-cycle pulse per completed window
//   busy            run in progress
//   done            one-cycle pulse at the end of a run
// ---------------------------------------------------------------------------
module feature_col_feeder #(
  parameter int       Tn                 = 2,
  parameter int       KERNEL_SIZE        = 5,
  parameter int       KERNEL_SIZE_3      = 3,
  parameter int       FEATURE_WIDTH      = 8,
  parameter logic     KERNEL_SIZE_5_MODE = 1'b1,
  parameter logic     KERNEL_SIZE_3_MODE = 1'b0,
  parameter int       ADDR_WIDTH         = 12,
  parameter int       CNT_WIDTH          = 8,
  localparam int      DW                 = Tn * KERNEL_SIZE * FEATURE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kn_size_mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  col_stride,
  input  logic [CNT_WIDTH-1:0]  num_windows,
  input  logic                  compute_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DW-1:0]         rd_data,
  output logic                  enable,
  output logic                  in_select,
  output logic [DW-1:0]         dia_0,
  output logic [DW-1:0]         dia_1,
  input  logic                  shift_done,
  output logic                  win_loaded,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, WAIT_SD, NEXT, FIN} state_t;

  state_t                state_reg;
  logic [2:0]            k_last_reg;    // K-1 for the current run
  logic [2:0]            col_reg;       // column index j being read
  logic [ADDR_WIDTH-1:0] win_addr_reg;  // origin of the current window
  logic [CNT_WIDTH-1:0]  stride_reg;
  logic [CNT_WIDTH-1:0]  num_reg;
  logic [CNT_WIDTH-1:0]  win_cnt_reg;
  logic                  cap_reg;       // rd_data is valid this cycle

  logic [ADDR_WIDTH-1:0] next_win_addr;
  assign next_win_addr = win_addr_reg + ADDR_WIDTH'(stride_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      k_last_reg   <= '0;
      col_reg      <= '0;
      win_addr_reg <= '0;
      stride_reg   <= '0;
      num_reg      <= '0;
      win_cnt_reg  <= '0;
      cap_reg      <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      enable       <= 1'b0;
      in_select    <= 1'b0;
      dia_0        <= '0;
      dia_1        <= '0;
      win_loaded   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Read data arrives one cycle after the strobe; in_select cannot change
      // while a window's columns are in flight, so it picks the bus directly.
      cap_reg <= rd_en;
      if (cap_reg) begin
        if (in_select) dia_1 <= rd_data;
        else           dia_0 <= rd_data;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            k_last_reg   <= (kn_size_mode == KERNEL_SIZE_5_MODE) ? 3'(KERNEL_SIZE - 1)
                                                                 : 3'(KERNEL_SIZE_3 - 1);
            win_addr_reg <= base_addr;
            stride_reg   <= col_stride;
            num_reg      <= num_windows;
            busy         <= 1'b1;
            state_reg    <= CHECK;
          end
        end

        CHECK: begin
          win_cnt_reg <= '0;
          if (num_reg == '0) begin
            done      <= 1'b1;
            state_reg <= FIN;
          end else begin
            rd_en     <= 1'b1;
            rd_addr   <= win_addr_reg;
            enable    <= 1'b1;
            col_reg   <= '0;
            state_reg <= LOAD;
          end
        end

        LOAD: begin
          enable <= 1'b0;
          if (col_reg == k_last_reg) begin
            rd_en     <= 1'b0;
            state_reg <= WAIT_SD;
          end else begin
            col_reg <= col_reg + 3'd1;
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
        end

        WAIT_SD: begin
          if (shift_done) begin
            win_loaded  <= 1'b1;
            in_select   <= ~in_select;
            win_cnt_reg <= win_cnt_reg + CNT_WIDTH'(1);
            state_reg   <= NEXT;
          end
        end

        NEXT: begin
          win_loaded <= 1'b0;
          if (win_cnt_reg == num_reg) begin
            done      <= 1'b1;
            state_reg <= FIN;
          end else if (compute_ready) begin
            win_addr_reg <= next_win_addr;
            rd_addr      <= next_win_addr;
            rd_en        <= 1'b1;
            enable       <= 1'b1;
            col_reg      <= '0;
            state_reg    <= LOAD;
          end
        end

        FIN: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_col_feeder.sv
module tb_feature_col_feeder;
  localparam int TN = 2;
  localparam int FW = 8;
  localparam int AW = 12;
  localparam int CW = 8;
  localparam int DW = TN * 5 * FW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          kn_size_mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] col_stride = '0;
  logic [CW-1:0] num_windows = '0;
  logic          compute_ready = 1'b1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          enable;
  logic          in_select;
  logic [DW-1:0] dia_0;
  logic [DW-1:0] dia_1;
  logic          shift_done = 1'b0;
  logic          win_loaded;
  logic          busy;
  logic          done;

  feature_col_feeder #(
    .Tn(TN), .KERNEL_SIZE(5), .KERNEL_SIZE_3(3), .FEATURE_WIDTH(FW),
    .KERNEL_SIZE_5_MODE(1'b1), .KERNEL_SIZE_3_MODE(1'b0),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .kn_size_mode(kn_size_mode),
    .base_addr(base_addr), .col_stride(col_stride), .num_windows(num_windows),
    .compute_ready(compute_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .enable(enable), .in_select(in_select),
    .dia_0(dia_0), .dia_1(dia_1), .shift_done(shift_done),
    .win_loaded(win_loaded), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Line-buffer model: random contents, 1-cycle read latency.
  logic [DW-1:0] mem [4096];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: which bus the next window targets, and what each bus
  // should currently hold.
  typedef struct {int due; bit bus; logic [DW-1:0] d;} pend_t;
  pend_t         pend [$];
  bit            exp_sel = 1'b0;
  logic [DW-1:0] mb [2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".rd_en"}, DW'(rd_en), '0);
    chk({tag, ".rd_addr"}, DW'(rd_addr), '0);
    chk({tag, ".enable"}, DW'(enable), '0);
    chk({tag, ".in_select"}, DW'(in_select), '0);
    chk({tag, ".dia_0"}, dia_0, '0);
    chk({tag, ".dia_1"}, dia_1, '0);
    chk({tag, ".win_loaded"}, DW'(win_loaded), '0);
    chk({tag, ".busy"}, DW'(busy), '0);
    chk({tag, ".done"}, DW'(done), '0);
  endtask

  task automatic do_abort();
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_sel = 1'b0;
    mb[0] = '0;
    mb[1] = '0;
    pend.delete();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    shift_done = 1'b0;
    compute_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort.rd_en", DW'(rd_en), '0);
      chk("post_abort.enable", DW'(enable), '0);
      chk("post_abort.busy", DW'(busy), '0);
    end
  endtask

  // One run, checked cycle by cycle. Called at a negedge; cycle 0 is the
  // cycle in which start is presented.
  task automatic run(input int k5, input int base, input int stride, input int num,
                     input int stall, input bit spurious, input bit repulse, input bit abort);
    int K, T, sd, w, done_c, st, ea;
    bit exp_rd, ok_end;
    K = k5 ? 5 : 3;
    kn_size_mode = k5 ? 1'b1 : 1'b0;
    base_addr = AW'(base);
    col_stride = CW'(stride);
    num_windows = CW'(num);
    start = 1'b1;
    shift_done = 1'b0;
    compute_ready = 1'b1;
    T = -1; sd = -1; w = 0; st = 0; ok_end = 0;
    if (num == 0) done_c = 2;
    else begin done_c = -1; T = 2; end
    $display("run: K=%0d base=%03h stride=%0d num=%0d stall=%0d spur=%0d repulse=%0d abort=%0d",
             K, base, stride, num, stall, spurious, repulse, abort);
    for (int c = 0; c < 3000; c++) begin
      if (sd >= 0 && c == sd + 1) begin
        exp_sel = ~exp_sel;
        w++;
        if (w == num) begin done_c = sd + 2; T = -1; end
        else begin
          st = (stall >= 0) ? stall : int'($urandom_range(0, 4));
          T = sd + 2 + st;
        end
      end
      while (pend.size() > 0 && pend[0].due == c) begin
        mb[pend[0].bus] = pend[0].d;
        void'(pend.pop_front());
      end
      exp_rd = (T >= 0 && c >= T && c < T + K);
      chk("rd_en", DW'(rd_en), DW'(exp_rd));
      chk("enable", DW'(enable), DW'(c == T));
      chk("win_loaded", DW'(win_loaded), DW'(sd >= 0 && c == sd + 1));
      chk("done", DW'(done), DW'(c == done_c));
      chk("busy", DW'(busy), DW'(c >= 1 && (done_c < 0 || c <= done_c)));
      chk("in_select", DW'(in_select), DW'(exp_sel));
      chk("dia_0", dia_0, mb[0]);
      chk("dia_1", dia_1, mb[1]);
      if (exp_rd) begin
        ea = (base + w * stride + (c - T)) % 4096;
        chk("rd_addr", DW'(rd_addr), DW'(ea));
        pend.push_back('{due: c + 2, bus: exp_sel, d: mem[ea]});
      end
      if (c == T) sd = T + K + 2 + int'($urandom_range(0, 3));
      if (abort && w == 0 && T >= 0 && c == T + 2) begin
        do_abort();
        return;
      end
      if (done_c >= 0 && c == done_c + 2) begin
        ok_end = 1;
        break;
      end
      // Inputs for this cycle. Pins are scrambled after start so that only
      // the values latched at the accepted start can matter.
      start = (c == 0) || (repulse && c == 4);
      if (c >= 1) begin
        base_addr    = AW'($urandom);
        col_stride   = CW'($urandom);
        num_windows  = CW'($urandom);
        kn_size_mode = 1'($urandom);
      end
      shift_done    = (c == sd) || (spurious && T >= 0 && c == T + 1);
      compute_ready = !(sd >= 0 && c > sd && c <= sd + st);
      @(negedge clk);
    end
    if (!ok_end) chk("run_timeout", '0, DW'(1));
    start = 1'b0;
    shift_done = 1'b0;
    compute_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'({$urandom, $urandom, $urandom});
    mb[0] = '0;
    mb[1] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run(1, 'h010, 1, 2, 0, 0, 0, 0);
    run(0, 'hFFE, 2, 2, 0, 0, 0, 0);
    run(1, 'h100, 3, 0, 0, 0, 0, 0);
    run(1, 'h200, 4, 3, 10, 0, 0, 0);
    run(0, 'h300, 5, 3, -1, 1, 1, 0);
    repeat (6)
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
          int'($urandom_range(0, 255)), int'($urandom_range(1, 4)),
          -1, 1'($urandom), 1'b0, 1'b0);
    if (exp_sel == 1'b0) run(1, 'h050, 1, 1, 0, 0, 0, 0);
    run(1, 'h060, 2, 3, 0, 0, 0, 1);
    run(0, 'h070, 1, 2, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
